// File: rtl/network_sequencer_if.sv
// Handshake bundle between the 9-9-1 network sequencer, its controller and the shared neuron engine.
// master: the sequencer side; slave: the controller/engine side.
interface network_sequencer_if #(
  parameter int W = 33,
  parameter int N = 9
);
  logic             start;
  logic [N*W-1:0]   in_vec;
  logic [N*W-1:0]   neu_in;
  logic             neu_start;
  logic             neu_done;
  logic [W:0]       neu_out;
  logic [1:0]       w_layer;
  logic [3:0]       w_neuron;
  logic             busy;
  logic [W:0]       result;
  logic             done;
  logic             err;

  modport master (
    input  start, in_vec, neu_done, neu_out,
    output neu_in, neu_start, w_layer, w_neuron, busy, result, done, err
  );

  modport slave (
    output start, in_vec, neu_done, neu_out,
    input  neu_in, neu_start, w_layer, w_neuron, busy, result, done, err
  );
endinterface

// File: rtl/network_sequencer.sv
// Time-multiplexes one 9-input neuron engine over a 9-9-1 network using two
// ping-pong activation buffers; hidden-layer results are saturated to W bits.
module network_sequencer #(
  parameter int W       = 33,
  parameter int N       = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  network_sequencer_if.master    bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_ERR} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   buf_a_reg [N];
  logic [W-1:0]   buf_b_reg [N];
  logic [1:0]     layer_reg;
  logic [3:0]     idx_reg;
  logic [TW-1:0]  timer_reg;
  logic [W:0]     cap_reg;
  logic [W:0]     result_reg;
  logic           done_reg;
  logic           err_reg;
  logic [N*W-1:0] neu_in_vec;
  logic [W-1:0]   sat_val;

  function automatic logic [W-1:0] sat(input logic [W:0] x);
    if (x[W] != x[W-1])
      sat = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat = x[W-1:0];
  endfunction

  assign sat_val = sat(cap_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (bus.neu_done)                       state_next = S_STORE;
        else if (timer_reg == TW'(TIMEOUT - 1)) state_next = S_ERR;
      end
      S_STORE: state_next = (layer_reg == 2'd2) ? S_IDLE : S_ISSUE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // err is raised on the edge into ERR so it is already visible during the ERR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_reg  <= '0;
      idx_reg    <= '0;
      timer_reg  <= '0;
      cap_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_STORE) && (layer_reg == 2'd2);
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            layer_reg <= '0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
          end
        end
        S_ISSUE: timer_reg <= '0;
        S_WAIT: begin
          if (bus.neu_done) begin
            cap_reg <= bus.neu_out;
          end else begin
            timer_reg <= timer_reg + TW'(1);
            if (timer_reg == TW'(TIMEOUT - 1)) err_reg <= 1'b1;
          end
        end
        S_STORE: begin
          if (layer_reg == 2'd2) begin
            result_reg <= cap_reg;
          end else if (idx_reg == 4'(N - 1)) begin
            layer_reg <= layer_reg + 2'd1;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Layer 0 reads A and fills B; layer 1 reads B and refills A; layer 2 reads A.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_buf
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          buf_a_reg[gi] <= '0;
        else if (state_reg == S_IDLE && bus.start)
          buf_a_reg[gi] <= bus.in_vec[gi*W +: W];
        else if (state_reg == S_STORE && layer_reg == 2'd1 && idx_reg == 4'(gi))
          buf_a_reg[gi] <= sat_val;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          buf_b_reg[gi] <= '0;
        else if (state_reg == S_STORE && layer_reg == 2'd0 && idx_reg == 4'(gi))
          buf_b_reg[gi] <= sat_val;
      end

      assign neu_in_vec[gi*W +: W] = (layer_reg == 2'd1) ? buf_b_reg[gi] : buf_a_reg[gi];
    end
  endgenerate

  assign bus.neu_in = neu_in_vec;

  always_comb begin
    bus.neu_start = (state_reg == S_ISSUE);
    bus.busy      = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_STORE);
    bus.w_layer   = layer_reg;
    bus.w_neuron  = idx_reg;
    bus.result    = result_reg;
    bus.done      = done_reg;
    bus.err       = err_reg;
  end

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Time-multiplexes one shared 9-input neuron engine across the 9-9-1 fully connected network: layer 0 (9 neurons), layer 1 (9 neurons), layer 2 (1 neuron). 19 evaluations per inference.
- Owns two 9-entry ping-pong activation buffers.
- Drives the engine's start/done handshake and the weight-ROM row address.
- Returns the final 34-bit output with a done pulse.

Parameters:
- W, 33, activation/input width (signed)
- N, 9, inputs per neuron and neurons per hidden layer
- TIMEOUT, 255, maximum WAIT cycles before error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled in IDLE only
- in_vec  in  N*W  network inputs; element k at [k*W +: W]
- neu_in  out  N*W  operand vector to engine; element k at [k*W +: W]
- neu_start  out  1  one-cycle engine start pulse
- neu_done  in  1  engine result-valid pulse
- neu_out  in  W+1  engine result (signed)
- w_layer  out  2  weight-ROM layer select (0..2)
- w_neuron  out  4  weight-ROM neuron select (0..8)
- busy  out  1  high from ISSUE of the first neuron through the final STORE
- result  out  W+1  final network output
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag

Behaviour:
- Reset, asynchronous, immediate on assertion:
  - state=IDLE.
  - All outputs are 0.
  - Both buffers cleared to 0.
  - layer, idx and timer counters are 0.
- IDLE:
  - busy=0.
  - If start=1: latch in_vec into buffer A, set layer=0, idx=0, clear err, go to ISSUE.
- ISSUE (1 cycle):
  - neu_start=1.
  - w_layer=layer and w_neuron=idx, both held stable from ISSUE through STORE.
  - neu_in source: buffer A for layers 0 and 2, buffer B for layer 1. neu_in is stable ISSUE through STORE.
  - Go to WAIT; timer=0.
  - neu_done is ignored in this cycle.
- WAIT:
  - If neu_done=1: capture neu_out, go to STORE.
  - Otherwise timer++. When timer reaches TIMEOUT, go to ERR.
- STORE (1 cycle):
  - Layer 0: write sat(neu_out) to B[idx].
  - Layer 1: write sat(neu_out) to A[idx].
  - If layer<2 and idx<8: idx++, go to ISSUE.
  - If layer<2 and idx==8: layer++, idx=0, go to ISSUE.
  - If layer==2: result <= neu_out, unsaturated; go to IDLE. done=1 in the following cycle only.
- ERR (1 cycle):
  - err <= 1, busy=0, go to IDLE.
  - err holds until the next accepted start.
  - result is unchanged.
- sat(): clips a 34-bit signed value to 33-bit signed, range [-2^32, 2^32-1]. Applies to hidden layers only.
- result holds its value until the next completed inference.
- Latency, with engine done L≥1 cycles after its neu_start cycle:
  - Per neuron: L+2 cycles.
  - start accepted at edge 0: first ISSUE in cycle 1, done=1 in cycle 19(L+2)+1.
- start while busy is ignored. start held high continuously re-triggers only from IDLE, i.e. the cycle after done.
- A neu_done outside WAIT is ignored.
- Back-to-back inferences are allowed: start in the done cycle is accepted.
- in_vec is sampled only on the accepting edge; later changes have no effect.

Test Plan:
1. Stub engine, L=3, always returns 5; pulse start.
   - Required: exactly 19 neu_start pulses.
   - (w_layer,w_neuron) sequence: (0,0..8), (1,0..8), (2,0).
   - done in cycle 96; result=5.
   - busy low after completion; err=0.
2. Stub returns the sum of neu_in, L=1; in_vec all 1.
   - Required: layer-1 neu_in elements all 9.
   - Layer-2 neu_in elements all 81.
   - result=729; done in cycle 58.
3. Stub returns 2^33-1 for layers 0-1 and -2^33 for layer 2.
   - Required: layer-1 and layer-2 neu_in elements equal 2^32-1.
   - result=-2^33, not clipped.
4. TIMEOUT=16; stub never asserts done.
   - Required: single neu_start in cycle 1.
   - err=1 in cycle 18; busy=0; done never pulses.
   - A following start clears err, and the run completes with a working stub.
5. start held high for the entire run; extra neu_done pulses injected during ISSUE/STORE.
   - Required: still exactly 19 neu_start pulses; injected pulses ignored.
   - Identical result to scenario 2.
   - A second run begins in the cycle after done.
6. rst asserted asynchronously mid-cycle during layer-1 WAIT.
   - Required: busy, neu_start, done, err and result go to 0 without a clock edge.
   - After release, a fresh start gives scenario-2 results exactly.
